vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 14 +
 rtl/vram_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: default bus widths and the
// grant tag remembered from one cycle to the next.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_WIDTH = 16;
  localparam int unsigned VRAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2
  } last_grant_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between video scanout and the CPU.
//
// last_grant | meaning
// -----------+--------------------------------------------------------
// NONE       | no access last cycle, nothing returns this cycle
// VID        | video read issued last cycle, ram_rdata is video data
// CPU        | CPU access issued last cycle, cpu_done pulses this cycle
//
// Video normally wins; starve_cnt counts video grants taken while the CPU
// waits, and once it reaches MAX_VID_BURST the CPU gets the next slot.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = VRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = VRAM_DATA_WIDTH,
  parameter int unsigned MAX_VID_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_gnt,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  output logic                  vid_valid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_VID_BURST);

  last_grant_e           last_grant_q, last_grant_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  cpu_rd_q, cpu_rd_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic                  cpu_wins;

  // Grant decision: CPU only beats video once video has had its burst.
  always_comb begin
    cpu_wins = cpu_req & (~vid_req | (starve_cnt_q == BURST_LIMIT));
    cpu_gnt  = ~reset & cpu_wins;
    vid_gnt  = ~reset & vid_req & ~cpu_wins;
  end

  // Next-state: grant tag, read/write flavour of a CPU access, starvation count.
  always_comb begin
    last_grant_d = NONE;
    cpu_rd_d     = cpu_rd_q;
    starve_cnt_d = starve_cnt_q;
    if (vid_gnt) begin
      last_grant_d = VID;
    end else if (cpu_gnt) begin
      last_grant_d = CPU;
      cpu_rd_d     = ~cpu_we;
    end
    if (~cpu_req | cpu_gnt) begin
      starve_cnt_d = '0;
    end else if (vid_gnt && (starve_cnt_q != BURST_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // RAM port mux and return-path outputs; the address parks when idle.
  always_comb begin
    ram_addr  = ram_addr_q;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (reset) begin
      ram_addr = '0;
    end else if (vid_gnt) begin
      ram_addr = vid_addr;
    end else if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end
    vid_valid = ~reset & (last_grant_q == VID);
    vid_rdata = vid_valid ? ram_rdata : '0;
    cpu_done  = ~reset & (last_grant_q == CPU);
    cpu_rdata = (cpu_done & cpu_rd_q) ? ram_rdata : cpu_rdata_q;
  end

  // State registers; reset drops any access still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= NONE;
      starve_cnt_q <= '0;
      cpu_rd_q     <= 1'b0;
      ram_addr_q   <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_rd_q     <= cpu_rd_d;
      ram_addr_q   <= ram_addr;
      cpu_rdata_q  <= cpu_rdata;
    end
  end

endmodule
